neo_load_arbiter: RTL and testbench

Two-requester arbiter that shares the single NeoPixel driver load/send interface between independent pattern producers, e.g. the hue-sequencing producer and a switch-driven producer. A grant is frame-atomic: the winning requester owns the driver through all its loads, one send, and the driver's latch wait. Only then does round-robin arbitration hand the driver to the other requester. The block sits between the producer FSMs and the NeoPixel driver.

---
 rtl/neo_load_arbiter_if.sv | 59 +++++
 rtl/neo_load_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_neo_load_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neo_load_arbiter_if.sv
// -----------------------------------------------------------------------------
// neo_load_arbiter_if
// Bundles the signals between two pattern producers, the arbiter and the
// NeoPixel driver.
//
// Requester side (index i = 0/1):
//   req, req_load, req_send           : per-requester request strobes
//   req_pixel_index/color_index/level : per-requester load word
//   gnt, load_ack, send_ack           : one-hot grant and one-cycle accept pulses
// Driver side:
//   ready_to_load, ready_to_send      : driver readiness
//   done_send, done_wait              : shift finished / latch wait finished
//   pixel_index, color_index,
//   color_level, load_color, send_it  : muxed load word and driver strobes
// Status:
//   busy, timeout
//
// Modports:
//   slave  : the arbiter's view
//   master : the view of everything around it (producers plus driver)
// -----------------------------------------------------------------------------
interface neo_load_arbiter_if;
  logic [1:0]      req;
  logic [1:0]      req_load;
  logic [1:0][2:0] req_pixel_index;
  logic [1:0][1:0] req_color_index;
  logic [1:0][7:0] req_color_level;
  logic [1:0]      req_send;

  logic            ready_to_load;
  logic            ready_to_send;
  logic            done_send;
  logic            done_wait;

  logic [1:0]      gnt;
  logic [1:0]      load_ack;
  logic [1:0]      send_ack;
  logic [2:0]      pixel_index;
  logic [1:0]      color_index;
  logic [7:0]      color_level;
  logic            load_color;
  logic            send_it;
  logic            busy;
  logic            timeout;

  modport slave (
    input  req, req_load, req_pixel_index, req_color_index, req_color_level,
    input  req_send, ready_to_load, ready_to_send, done_send, done_wait,
    output gnt, load_ack, send_ack, pixel_index, color_index, color_level,
    output load_color, send_it, busy, timeout
  );

  modport master (
    output req, req_load, req_pixel_index, req_color_index, req_color_level,
    output req_send, ready_to_load, ready_to_send, done_send, done_wait,
    input  gnt, load_ack, send_ack, pixel_index, color_index, color_level,
    input  load_color, send_it, busy, timeout
  );
endinterface

// File: rtl/neo_load_arbiter.sv
// -----------------------------------------------------------------------------
// neo_load_arbiter
// Shares one NeoPixel driver between two pattern producers. A grant is
// frame-atomic: the owner keeps the driver through its loads, one send and
// the driver's latch wait. Round-robin then prefers the other requester.
//
// Ports:
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : neo_load_arbiter_if.slave (requester handshakes, driver strobes,
//           muxed load word, busy and timeout status)
//
// Parameters:
//   MAX_LOADS      : loads accepted per grant; further loads are not acked
//   TIMEOUT_CYCLES : idle-grant watchdog limit (only with NEO_ARB_TIMEOUT_EN)
//
// Optional feature macro: NEO_ARB_TIMEOUT_EN
//   Defined   : a watchdog counts LOAD cycles without an ack and forces a
//               release, pulsing timeout, after TIMEOUT_CYCLES such cycles.
//   Undefined : no watchdog, timeout is tied 0.
// -----------------------------------------------------------------------------
module neo_load_arbiter #(
  parameter int MAX_LOADS      = 15,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset,
  neo_load_arbiter_if.slave  bus
);

  localparam int                CNT_W   = $clog2(MAX_LOADS + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_LOADS);

  if (MAX_LOADS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("neo_load_arbiter: MAX_LOADS and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

  state_t           state_q, state_nxt;
  logic [1:0]       gnt_q, gnt_nxt;
  logic             rr_q, rr_nxt;
  logic [CNT_W-1:0] load_count_q, load_count_nxt;

  logic g;          // index of the current owner (valid while gnt_q != 0)
  logic owner_req;
  logic load_ok;
  logic send_ok;
  logic wd_expire;
  logic win;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX_CNT) ? v : v + CNT_W'(1);
  endfunction

  assign g         = gnt_q[1];
  assign owner_req = bus.req[g];

  // Load beats send in the same cycle; the send simply retries next cycle.
  assign load_ok = (state_q == LOAD) && owner_req && bus.req_load[g] &&
                   bus.ready_to_load && (load_count_q < MAX_CNT);
  assign send_ok = (state_q == LOAD) && owner_req && !load_ok &&
                   bus.req_send[g] && bus.ready_to_send;

`ifdef NEO_ARB_TIMEOUT_EN
  localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive LOAD cycle with no ack.
  assign wd_expire = (state_q == LOAD) && owner_req && !load_ok && !send_ok &&
                     (wd_q == WD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q <= '0;
    end else if (state_q != LOAD || load_ok || send_ok) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= 2'b00;
      rr_q         <= 1'b0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_nxt;
      gnt_q        <= gnt_nxt;
      rr_q         <= rr_nxt;
      load_count_q <= load_count_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt      = state_q;
    gnt_nxt        = gnt_q;
    rr_nxt         = rr_q;
    load_count_nxt = load_count_q;

    // Only one requester: it wins. Both: the rr-preferred one wins.
    case (bus.req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = rr_q;
      default: win = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_nxt      = LOAD;
          gnt_nxt        = win ? 2'b10 : 2'b01;
          load_count_nxt = '0;
        end
      end
      LOAD: begin
        if (!owner_req || wd_expire) begin
          state_nxt = IDLE;
          gnt_nxt   = 2'b00;
          rr_nxt    = ~g;
        end else if (load_ok) begin
          load_count_nxt = sat_inc(load_count_q);
        end else if (send_ok) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (bus.done_send) begin
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        if (bus.done_wait) begin
          state_nxt = IDLE;
          gnt_nxt   = 2'b00;
          rr_nxt    = ~g;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus.load_ack    = 2'b00;
    bus.send_ack    = 2'b00;
    bus.load_color  = 1'b0;
    bus.send_it     = 1'b0;
    bus.pixel_index = 3'd0;
    bus.color_index = 2'd0;
    bus.color_level = 8'd0;

    if (load_ok) begin
      bus.load_ack[g] = 1'b1;
      bus.load_color  = 1'b1;
      bus.pixel_index = bus.req_pixel_index[g];
      bus.color_index = bus.req_color_index[g];
      bus.color_level = bus.req_color_level[g];
    end

    if (send_ok) begin
      bus.send_ack[g] = 1'b1;
      bus.send_it     = 1'b1;
    end

    bus.busy    = (state_q != IDLE);
    bus.timeout = wd_expire;
  end

  assign bus.gnt = gnt_q;

endmodule

// File: tb/tb_neo_load_arbiter.sv
// -----------------------------------------------------------------------------
// tb_neo_load_arbiter
// Directed, self-checking bench for neo_load_arbiter. Inputs are driven 1 time
// unit after the rising edge; outputs are sampled 1 time unit later, well
// before the next rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_neo_load_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  neo_load_arbiter_if bus();

  neo_load_arbiter #(
    .MAX_LOADS      (15),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.req             = 2'b00;
    bus.req_load        = 2'b00;
    bus.req_send        = 2'b00;
    bus.req_pixel_index = '0;
    bus.req_color_index = '0;
    bus.req_color_level = '0;
    bus.ready_to_load   = 1'b0;
    bus.ready_to_send   = 1'b0;
    bus.done_send       = 1'b0;
    bus.done_wait       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drives the driver through shift and latch completion; caller has already
  // dropped req for the sender while the arbiter sits in SEND.
  task automatic finish_frame();
    bus.req_send      = 2'b00;
    bus.req_load      = 2'b00;
    bus.ready_to_send = 1'b0;
    bus.done_send     = 1'b1;
    tick();
    bus.done_send     = 1'b0;
    bus.done_wait     = 1'b1;
    tick();
    bus.done_wait     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    bus.req = 2'b11;
    tick();
    settle();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if ({bus.load_ack, bus.send_ack, bus.load_color, bus.send_it, bus.timeout} !== 7'b0)
      begin errors++; $display("FAIL reset_strobes got=%b exp=0000000",
        {bus.load_ack, bus.send_ack, bus.load_color, bus.send_it, bus.timeout}); end
    checks++; if ({bus.pixel_index, bus.color_index, bus.color_level} !== 13'h0)
      begin errors++; $display("FAIL reset_data got=%h exp=0",
        {bus.pixel_index, bus.color_index, bus.color_level}); end
    reset   = 1'b0;
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_single_frame();
    int         acks;
    logic [2:0] px;
    logic [1:0] cx;
    do_reset();
    bus.req = 2'b01;
    settle();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL frame_gnt_early got=%b exp=00", bus.gnt); end
    tick();
    checks++; if ({bus.gnt, bus.busy} !== 3'b011) begin errors++; $display("FAIL frame_gnt got=%b exp=011", {bus.gnt, bus.busy}); end
    acks = 0;
    bus.ready_to_load      = 1'b1;
    bus.req_pixel_index[1] = 3'd7;
    bus.req_color_level[1] = 8'hff;
    for (int k = 0; k < 15; k++) begin
      px = 3'(k / 3);
      cx = 2'(k % 3);
      bus.req_load           = 2'b01;
      bus.req_pixel_index[0] = px;
      bus.req_color_index[0] = cx;
      bus.req_color_level[0] = 8'h20;
      settle();
      if (bus.load_ack === 2'b01 && bus.load_color === 1'b1) acks++;
      checks++; if ({bus.pixel_index, bus.color_index, bus.color_level} !== {px, cx, 8'h20})
        begin errors++; $display("FAIL frame_data[%0d] got=%h exp=%h", k,
          {bus.pixel_index, bus.color_index, bus.color_level}, {px, cx, 8'h20}); end
      tick();
    end
    bus.req_load      = 2'b00;
    bus.ready_to_load = 1'b0;
    checks++; if (acks != 15) begin errors++; $display("FAIL frame_load_acks got=%0d exp=15", acks); end
    bus.req_send      = 2'b01;
    bus.ready_to_send = 1'b1;
    settle();
    checks++; if ({bus.send_it, bus.send_ack} !== 3'b101) begin errors++; $display("FAIL frame_send got=%b exp=101", {bus.send_it, bus.send_ack}); end
    tick();
    bus.req_send      = 2'b00;
    bus.ready_to_send = 1'b0;
    bus.req           = 2'b00;
    settle();
    checks++; if ({bus.send_it, bus.busy} !== 2'b01) begin errors++; $display("FAIL frame_in_send got=%b exp=01", {bus.send_it, bus.busy}); end
    bus.done_wait = 1'b1;
    tick();
    bus.done_wait = 1'b0;
    settle();
    checks++; if ({bus.gnt, bus.busy} !== 3'b011) begin errors++; $display("FAIL frame_done_wait_ignored got=%b exp=011", {bus.gnt, bus.busy}); end
    finish_frame();
    settle();
    checks++; if ({bus.gnt, bus.busy} !== 3'b000) begin errors++; $display("FAIL frame_release got=%b exp=000", {bus.gnt, bus.busy}); end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req = 2'b11;
    tick();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rr_first got=%b exp=01", bus.gnt); end
    bus.req_send      = 2'b01;
    bus.ready_to_send = 1'b1;
    settle();
    checks++; if (bus.send_ack !== 2'b01) begin errors++; $display("FAIL rr_empty_send got=%b exp=01", bus.send_ack); end
    tick();
    bus.req = 2'b10;
    finish_frame();
    bus.req = 2'b11;
    settle();
    checks++; if ({bus.gnt, bus.busy} !== 3'b000) begin errors++; $display("FAIL rr_idle_gap got=%b exp=000", {bus.gnt, bus.busy}); end
    tick();
    checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL rr_second got=%b exp=10", bus.gnt); end
    bus.req = 2'b01;
    tick();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rr_drop_release got=%b exp=00", bus.gnt); end
    tick();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rr_third got=%b exp=01", bus.gnt); end
    bus.req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_max_loads();
    int acks;
    do_reset();
    bus.req = 2'b01;
    tick();
    bus.req_load           = 2'b01;
    bus.ready_to_load      = 1'b1;
    bus.req_pixel_index[0] = 3'd5;
    bus.req_color_index[0] = 2'd2;
    bus.req_color_level[0] = 8'h5a;
    acks = 0;
    for (int k = 0; k < 16; k++) begin
      settle();
      if (bus.load_ack === 2'b01) acks++;
      tick();
    end
    checks++; if (acks != 15) begin errors++; $display("FAIL max_load_acks got=%0d exp=15", acks); end
    settle();
    checks++; if ({bus.load_ack, bus.load_color} !== 3'b000) begin errors++; $display("FAIL max_pending got=%b exp=000", {bus.load_ack, bus.load_color}); end
    checks++; if ({bus.pixel_index, bus.color_index, bus.color_level} !== 13'h0)
      begin errors++; $display("FAIL max_data_zero got=%h exp=0", {bus.pixel_index, bus.color_index, bus.color_level}); end
    bus.req_send      = 2'b01;
    bus.ready_to_send = 1'b1;
    settle();
    checks++; if ({bus.send_it, bus.send_ack, bus.load_ack} !== 5'b10100) begin errors++;
      $display("FAIL max_send got=%b exp=10100", {bus.send_it, bus.send_ack, bus.load_ack}); end
    tick();
    bus.req = 2'b00;
    finish_frame();
  endtask

  task automatic test_load_send_collision();
    do_reset();
    bus.req = 2'b01;
    tick();
    bus.req_load           = 2'b01;
    bus.req_send           = 2'b01;
    bus.ready_to_load      = 1'b1;
    bus.ready_to_send      = 1'b1;
    bus.req_pixel_index[0] = 3'd3;
    bus.req_color_index[0] = 2'd1;
    bus.req_color_level[0] = 8'h77;
    settle();
    checks++; if ({bus.load_ack, bus.send_ack, bus.send_it} !== 5'b01000) begin errors++;
      $display("FAIL coll_load_first got=%b exp=01000", {bus.load_ack, bus.send_ack, bus.send_it}); end
    checks++; if (bus.color_level !== 8'h77) begin errors++; $display("FAIL coll_level got=%h exp=77", bus.color_level); end
    tick();
    bus.req_load = 2'b00;
    settle();
    checks++; if ({bus.load_ack, bus.send_ack, bus.send_it} !== 5'b00011) begin errors++;
      $display("FAIL coll_send_next got=%b exp=00011", {bus.load_ack, bus.send_ack, bus.send_it}); end
    tick();
    bus.req = 2'b00;
    finish_frame();
    settle();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL coll_release got=%b exp=0", bus.busy); end
  endtask

  task automatic test_stall();
    logic [6:0] ready_pat;
    logic [6:0] ack_pat;
    int         w;
    ready_pat = 7'b1100011;  // bit c = ready_to_load in cycle c
    ack_pat   = 7'b1100011;
    do_reset();
    bus.req = 2'b01;
    tick();
    bus.req_load = 2'b01;
    w = 0;
    for (int c = 0; c < 7; c++) begin
      bus.ready_to_load      = ready_pat[c];
      bus.req_pixel_index[0] = 3'(w);
      bus.req_color_index[0] = 2'(w % 3);
      bus.req_color_level[0] = 8'h10 + 8'(w);
      settle();
      checks++; if (bus.load_ack !== {1'b0, ack_pat[c]}) begin errors++;
        $display("FAIL stall_ack[%0d] got=%b exp=%b", c, bus.load_ack, {1'b0, ack_pat[c]}); end
      if (ack_pat[c]) begin
        checks++; if ({bus.load_color, bus.color_level} !== {1'b1, 8'h10 + 8'(w)}) begin errors++;
          $display("FAIL stall_word[%0d] got=%h exp=%h", c, {bus.load_color, bus.color_level}, {1'b1, 8'h10 + 8'(w)}); end
        w++;
      end else begin
        checks++; if ({bus.load_color, bus.color_level} !== 9'h0) begin errors++;
          $display("FAIL stall_idle[%0d] got=%h exp=0", c, {bus.load_color, bus.color_level}); end
      end
      tick();
    end
    bus.req_load      = 2'b00;
    bus.ready_to_load = 1'b0;
    bus.req_send      = 2'b01;
    bus.ready_to_send = 1'b1;
    tick();
    bus.req = 2'b00;
    finish_frame();
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    bus.req           = 2'b01;
    tick();
    bus.req_send      = 2'b01;
    bus.ready_to_send = 1'b1;
    tick();
    bus.req = 2'b00;
    finish_frame();
    bus.req = 2'b10;
    tick();
    checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL midrst_gnt got=%b exp=10", bus.gnt); end
    bus.req_load      = 2'b10;
    bus.ready_to_load = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    settle();
    checks++; if ({bus.gnt, bus.busy, bus.load_ack} !== 5'b00000) begin errors++;
      $display("FAIL midrst_state got=%b exp=00000", {bus.gnt, bus.busy, bus.load_ack}); end
    reset             = 1'b0;
    bus.req_load      = 2'b00;
    bus.ready_to_load = 1'b0;
    bus.req           = 2'b11;
    tick();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL midrst_rr got=%b exp=01", bus.gnt); end
    bus.req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req = 2'b11;
    tick();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL wd_gnt got=%b exp=01", bus.gnt); end
`ifdef NEO_ARB_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      settle();
      checks++; if (bus.timeout !== (c == 8)) begin errors++;
        $display("FAIL wd_pulse[%0d] got=%b exp=%b", c, bus.timeout, (c == 8)); end
      tick();
    end
    settle();
    checks++; if ({bus.gnt, bus.timeout} !== 3'b000) begin errors++; $display("FAIL wd_release got=%b exp=000", {bus.gnt, bus.timeout}); end
    tick();
    checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL wd_handover got=%b exp=10", bus.gnt); end
`else
    begin
      int seen;
      int lost;
      seen = 0;
      lost = 0;
      for (int c = 0; c < 40; c++) begin
        settle();
        if (bus.timeout !== 1'b0) seen++;
        if (bus.gnt !== 2'b01) lost++;
        tick();
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL wd_off_pulse got=%0d exp=0", seen); end
      checks++; if (lost != 0) begin errors++; $display("FAIL wd_off_hold got=%0d exp=0", lost); end
    end
`endif
    bus.req = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_max_loads();
    test_load_send_collision();
    test_stall();
    test_reset_mid_frame();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
